// File: rtl/branch_target_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_ctrl
//
// Owns a direct-mapped branch target buffer and arbitrates its single table
// port between fetch-stage prediction lookups and execute-stage resolution
// updates. Resolved branches are buffered in a small FIFO and committed when
// the port is free, or forcibly after MAX_WAIT consecutive lookup grants.
// Each commit applies the 2-bit saturating-counter transition to its entry.
//
// Optional feature macro: BTB_CTRL_FLUSH_EN
//   When defined, adds input btb_ctrl_flush. A flush pulse walks the table and
//   clears one valid bit per cycle over ENTRIES cycles. Lookups stall and
//   commits pause during the walk, but updates can still be enqueued.
//
// Ports
//   btb_ctrl_clk / btb_ctrl_rst_n  clock, asynchronous active-low reset
//   btb_ctrl_lookup_*              fetch lookup request (valid/ready handshake)
//   btb_ctrl_hit_*                 registered lookup result, one cycle later
//   btb_ctrl_update_*              resolved branch in (valid/ready handshake)
//   btb_ctrl_queue_count           number of queued, uncommitted updates
//   btb_ctrl_flush                 table flush request (BTB_CTRL_FLUSH_EN only)
// -----------------------------------------------------------------------------
module branch_target_buffer_ctrl #(
  parameter int ENTRIES   = 16,
  parameter int PC_W      = 32,
  parameter int UPD_DEPTH = 4,
  parameter int MAX_WAIT  = 3
) (
  input  logic                           btb_ctrl_clk,
  input  logic                           btb_ctrl_rst_n,
`ifdef BTB_CTRL_FLUSH_EN
  input  logic                           btb_ctrl_flush,
`endif
  input  logic                           btb_ctrl_lookup_valid,
  input  logic [PC_W-1:0]                btb_ctrl_lookup_pc,
  output logic                           btb_ctrl_lookup_ready,
  output logic                           btb_ctrl_hit_valid,
  output logic                           btb_ctrl_hit,
  output logic                           btb_ctrl_hit_taken,
  output logic [PC_W-1:0]                btb_ctrl_hit_target,
  input  logic                           btb_ctrl_update_valid,
  input  logic [PC_W-1:0]                btb_ctrl_update_pc,
  input  logic                           btb_ctrl_update_taken,
  input  logic [PC_W-1:0]                btb_ctrl_update_target,
  output logic                           btb_ctrl_update_ready,
  output logic [$clog2(UPD_DEPTH):0]     btb_ctrl_queue_count
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = PC_W - IDX_W - 2;
  localparam int PTR_W  = $clog2(UPD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int QPC_W  = PC_W - 2;   // the queue keeps only word-address bits

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] tbl_valid;
  logic [1:0]         tbl_ctr    [ENTRIES];
  logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
  logic [PC_W-1:0]    tbl_target [ENTRIES];

  logic [QPC_W-1:0]   q_pc       [UPD_DEPTH];
  logic               q_taken    [UPD_DEPTH];
  logic [PC_W-1:0]    q_target   [UPD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               res_valid;
  logic               res_hit;
  logic               res_taken;
  logic [PC_W-1:0]    res_target;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{btb_ctrl_lookup_pc[1:0], btb_ctrl_update_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Flush walker (optional)
  // ---------------------------------------------------------------------------
  logic flushing;

`ifdef BTB_CTRL_FLUSH_EN
  logic             flush_busy;
  logic [IDX_W-1:0] flush_idx;

  // A new flush request always restarts the walk at index 0.
  always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
    if (!btb_ctrl_rst_n) begin
      flush_busy <= 1'b0;
      flush_idx  <= '0;
    end else if (btb_ctrl_flush) begin
      flush_busy <= 1'b1;
      flush_idx  <= '0;
    end else if (flush_busy) begin
      flush_idx <= flush_idx + IDX_W'(1);
      if (flush_idx == IDX_W'(ENTRIES - 1)) flush_busy <= 1'b0;
    end
  end

  assign flushing = flush_busy;
`else
  assign flushing = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Port arbitration
  // ---------------------------------------------------------------------------
  logic       q_nonempty;
  logic       wait_max;
  logic       push;
  logic       pop;
  logic [1:0] state;

  assign q_nonempty = (count != '0);
  assign wait_max   = (wait_cnt == WAIT_W'(MAX_WAIT));

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state = ST_IDLE;
    if (flushing)                                          state = ST_FLUSH;
    else if (q_nonempty && (!btb_ctrl_lookup_valid || wait_max)) state = ST_UPDATE;
    else if (btb_ctrl_lookup_valid)                        state = ST_LOOKUP;
  end

  // Ready does not depend on lookup_valid, which keeps the fetch handshake
  // free of a combinational loop through the requester.
  assign btb_ctrl_lookup_ready = !flushing && !(q_nonempty && wait_max);
  // Derived from the registered count: a full queue rejects even while popping.
  assign btb_ctrl_update_ready = (count != CNT_W'(UPD_DEPTH));
  assign btb_ctrl_queue_count  = count;

  assign push = btb_ctrl_update_valid && btb_ctrl_update_ready;
  assign pop  = (state == ST_UPDATE);

  // ---------------------------------------------------------------------------
  // Update FIFO
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments for all clocked state, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
    if (!btb_ctrl_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; pointers and count alone decide which
  // slots hold live data, so clearing the array would buy nothing.
  always_ff @(posedge btb_ctrl_clk) begin
    if (push) begin
      q_pc[wr_ptr]     <= btb_ctrl_update_pc[PC_W-1:2];
      q_taken[wr_ptr]  <= btb_ctrl_update_taken;
      q_target[wr_ptr] <= btb_ctrl_update_target;
    end
  end

  always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
    if (!btb_ctrl_rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_UPDATE) begin
      wait_cnt <= '0;
    end else if ((state == ST_LOOKUP) && q_nonempty) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Table commit
  // ---------------------------------------------------------------------------
  logic [QPC_W-1:0] h_pc;
  logic [IDX_W-1:0] h_idx;
  logic [TAG_W-1:0] h_tag;
  logic             h_taken;
  logic [PC_W-1:0]  h_target;
  logic             h_hit;

  assign h_pc     = q_pc[rd_ptr];
  assign h_idx    = h_pc[IDX_W-1:0];
  assign h_tag    = h_pc[QPC_W-1:IDX_W];
  assign h_taken  = q_taken[rd_ptr];
  assign h_target = q_target[rd_ptr];
  assign h_hit    = tbl_valid[h_idx] && (tbl_tag[h_idx] == h_tag);

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
    if (!btb_ctrl_rst_n) begin
      tbl_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) tbl_ctr[i] <= 2'b00;
    end else begin
`ifdef BTB_CTRL_FLUSH_EN
      if (flushing) tbl_valid[flush_idx] <= 1'b0;
`endif
      if (pop) begin
        if (h_hit) begin
          tbl_ctr[h_idx] <= ctr_next(tbl_ctr[h_idx], h_taken);
        end else if (h_taken) begin
          // Miss with a taken outcome allocates as weak-taken, evicting the
          // previous occupant of this index.
          tbl_valid[h_idx] <= 1'b1;
          tbl_ctr[h_idx]   <= 2'b10;
        end
      end
    end
  end

  // Tag and target follow the valid bit; any taken commit writes both (on a
  // hit the tag is rewritten with the value it already holds).
  always_ff @(posedge btb_ctrl_clk) begin
    if (pop && h_taken) begin
      tbl_tag[h_idx]    <= h_tag;
      tbl_target[h_idx] <= h_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup and registered result
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic             do_lookup;

  assign l_idx     = btb_ctrl_lookup_pc[IDX_W+1:2];
  assign l_tag     = btb_ctrl_lookup_pc[PC_W-1:IDX_W+2];
  assign l_hit     = tbl_valid[l_idx] && (tbl_tag[l_idx] == l_tag);
  assign do_lookup = (state == ST_LOOKUP);

  // Result fields are forced to zero whenever there is no hit to report.
  always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
    if (!btb_ctrl_rst_n) begin
      res_valid  <= 1'b0;
      res_hit    <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
    end else begin
      res_valid  <= do_lookup;
      res_hit    <= do_lookup && l_hit;
      res_taken  <= do_lookup && l_hit && tbl_ctr[l_idx][1];
      res_target <= (do_lookup && l_hit) ? tbl_target[l_idx] : '0;
    end
  end

  assign btb_ctrl_hit_valid  = res_valid;
  assign btb_ctrl_hit        = res_hit;
  assign btb_ctrl_hit_taken  = res_taken;
  assign btb_ctrl_hit_target = res_target;

endmodule

// File: tb/tb_branch_target_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer_ctrl
//
// Directed bench for branch_target_buffer_ctrl. The stimulus thread sets the
// expected lookup result alongside each lookup request; a negedge monitor
// queues that expectation when the lookup is accepted and compares it against
// the registered result one cycle later. Queue, handshake and reset behaviour
// are checked inline by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer_ctrl;

  localparam int PC_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lookup_valid;
  logic [PC_W-1:0]   lookup_pc;
  logic              lookup_ready;
  logic              hit_valid;
  logic              hit;
  logic              hit_taken;
  logic [PC_W-1:0]   hit_target;
  logic              update_valid;
  logic [PC_W-1:0]   update_pc;
  logic              update_taken;
  logic [PC_W-1:0]   update_target;
  logic              update_ready;
  logic [2:0]        queue_count;
`ifdef BTB_CTRL_FLUSH_EN
  logic              flush;
`endif

  branch_target_buffer_ctrl #(
    .ENTRIES(16), .PC_W(PC_W), .UPD_DEPTH(4), .MAX_WAIT(3)
  ) dut (
    .btb_ctrl_clk          (clk),
    .btb_ctrl_rst_n        (rst_n),
`ifdef BTB_CTRL_FLUSH_EN
    .btb_ctrl_flush        (flush),
`endif
    .btb_ctrl_lookup_valid (lookup_valid),
    .btb_ctrl_lookup_pc    (lookup_pc),
    .btb_ctrl_lookup_ready (lookup_ready),
    .btb_ctrl_hit_valid    (hit_valid),
    .btb_ctrl_hit          (hit),
    .btb_ctrl_hit_taken    (hit_taken),
    .btb_ctrl_hit_target   (hit_target),
    .btb_ctrl_update_valid (update_valid),
    .btb_ctrl_update_pc    (update_pc),
    .btb_ctrl_update_taken (update_taken),
    .btb_ctrl_update_target(update_target),
    .btb_ctrl_update_ready (update_ready),
    .btb_ctrl_queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            hit;
    logic            taken;
    logic [PC_W-1:0] target;
  } res_t;

  res_t sb[$];
  res_t exp_now;
  res_t mon_r;
  logic pending = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [PC_W-1:0] obs,
                       input logic [PC_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic h, input logic t, input logic [PC_W-1:0] tgt);
    res_t r;
    r.hit    = h;
    r.taken  = t;
    r.target = tgt;
    return r;
  endfunction

  // Result monitor: compare last cycle's accepted lookup, then record this one.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pending = 1'b0;
    end else begin
      check("hit_valid", PC_W'(hit_valid), PC_W'(pending));
      if (pending) begin
        mon_r = sb.pop_front();
        if (hit_valid) begin
          check("hit", PC_W'(hit), PC_W'(mon_r.hit));
          check("hit_taken", PC_W'(hit_taken), PC_W'(mon_r.taken));
          check("hit_target", hit_target, mon_r.target);
        end
      end else if (!hit_valid) begin
        check("idle_hit", PC_W'(hit), '0);
        check("idle_taken", PC_W'(hit_taken), '0);
        check("idle_target", hit_target, '0);
      end
      pending = lookup_valid && lookup_ready;
      if (pending) sb.push_back(exp_now);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single accepted lookup with its expected result.
  task automatic lookup(input logic [PC_W-1:0] pc, input logic h, input logic t,
                        input logic [PC_W-1:0] tgt);
    exp_now      = mk(h, t, tgt);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    check("lookup_ready", PC_W'(lookup_ready), 1);
    tick();
    lookup_valid = 1'b0;
  endtask

  // Enqueue one update into an empty queue with fetch idle; it commits on the
  // following edge.
  task automatic upd_commit(input logic [PC_W-1:0] pc, input logic t,
                            input logic [PC_W-1:0] tgt);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_taken  = t;
    update_target = tgt;
    check("update_ready", PC_W'(update_ready), 1);
    tick();
    update_valid = 1'b0;
    check("qcount_enq", PC_W'(queue_count), 1);
    tick();
    check("qcount_commit", PC_W'(queue_count), 0);
  endtask

  initial begin
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_target = '0;
    exp_now       = '0;
`ifdef BTB_CTRL_FLUSH_EN
    flush         = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_hit_valid", PC_W'(hit_valid), 0);
    check("rst_hit", PC_W'(hit), 0);
    check("rst_taken", PC_W'(hit_taken), 0);
    check("rst_target", hit_target, 0);
    check("rst_lookup_ready", PC_W'(lookup_ready), 1);
    check("rst_update_ready", PC_W'(update_ready), 1);
    check("rst_qcount", PC_W'(queue_count), 0);

    // Cold miss
    lookup(32'h40, 1'b0, 1'b0, 32'h0);

    // Allocate as weak-taken
    upd_commit(32'h40, 1'b1, 32'h100);
    lookup(32'h40, 1'b1, 1'b1, 32'h100);

    // Two back-to-back not-taken: 10 -> 01 -> 00, target kept
    update_valid  = 1'b1;
    update_pc     = 32'h40;
    update_taken  = 1'b0;
    update_target = 32'hdead;
    tick();
    tick();
    update_valid = 1'b0;
    check("qcount_nt_pair", PC_W'(queue_count), 1);
    tick();
    check("qcount_nt_drain", PC_W'(queue_count), 0);
    lookup(32'h40, 1'b1, 1'b0, 32'h100);

    // Four taken: 00 -> 01 -> 10 -> 11 -> 11 (saturate)
    update_valid  = 1'b1;
    update_taken  = 1'b1;
    update_target = 32'h200;
    for (int k = 0; k < 4; k++) tick();
    update_valid = 1'b0;
    tick();
    tick();
    check("qcount_t4_drain", PC_W'(queue_count), 0);
    lookup(32'h40, 1'b1, 1'b1, 32'h200);
    upd_commit(32'h40, 1'b0, 32'h0);          // 11 -> 10
    lookup(32'h40, 1'b1, 1'b1, 32'h200);
    upd_commit(32'h40, 1'b0, 32'h0);          // 10 -> 01
    lookup(32'h40, 1'b1, 1'b0, 32'h200);

    // Same index, different tag
    lookup(32'h80, 1'b0, 1'b0, 32'h0);
    upd_commit(32'h80, 1'b0, 32'h999);        // miss not-taken: no change
    lookup(32'h40, 1'b1, 1'b0, 32'h200);
    lookup(32'h80, 1'b0, 1'b0, 32'h0);
    upd_commit(32'h80, 1'b1, 32'h300);        // miss taken: evicts 0x40
    lookup(32'h40, 1'b0, 1'b0, 32'h0);
    lookup(32'h80, 1'b1, 1'b1, 32'h300);

    // Starvation bound: three grants while pending, then a forced commit
    exp_now       = mk(1'b1, 1'b1, 32'h300);
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h80;
    update_valid  = 1'b1;
    update_pc     = 32'h44;
    update_taken  = 1'b1;
    update_target = 32'h500;
    check("mw_ready_empty", PC_W'(lookup_ready), 1);
    tick();
    update_valid = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      check("mw_ready_grant", PC_W'(lookup_ready), 1);
      check("mw_qcount", PC_W'(queue_count), 1);
      tick();
    end
    check("mw_ready_forced", PC_W'(lookup_ready), 0);
    tick();
    check("mw_qcount_after", PC_W'(queue_count), 0);
    lookup_pc = 32'h44;
    exp_now   = mk(1'b1, 1'b1, 32'h500);
    check("mw_ready_after", PC_W'(lookup_ready), 1);
    tick();
    lookup_valid = 1'b0;
    tick();

    // Overflow: five back-to-back updates with fetch busy; fifth is dropped
    exp_now      = mk(1'b1, 1'b1, 32'h300);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h80;
    update_taken = 1'b1;
    for (int k = 0; k < 5; k++) begin
      update_valid  = 1'b1;
      update_pc     = 32'h48 + 32'(4 * k);
      update_target = 32'h1000 + 32'(16 * k);
      check("ovf_update_ready", PC_W'(update_ready), PC_W'(k < 4));
      check("ovf_qcount", PC_W'(queue_count), PC_W'(k));
      if (k == 4) check("ovf_lookup_ready", PC_W'(lookup_ready), 0);
      tick();
    end
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    check("ovf_qcount_pop", PC_W'(queue_count), 3);
    repeat (3) tick();
    check("ovf_qcount_drain", PC_W'(queue_count), 0);
    for (int k = 0; k < 4; k++)
      lookup(32'h48 + 32'(4 * k), 1'b1, 1'b1, 32'h1000 + 32'(16 * k));
    lookup(32'h58, 1'b0, 1'b0, 32'h0);

    // Reset mid-operation discards the queued update and the pending result
    update_valid  = 1'b1;
    update_pc     = 32'h5c;
    update_taken  = 1'b1;
    update_target = 32'h77;
    exp_now       = mk(1'b1, 1'b1, 32'h1000);
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h48;
    tick();
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    check("mid_qcount", PC_W'(queue_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_qcount", PC_W'(queue_count), 0);
    check("mid_rst_hit_valid", PC_W'(hit_valid), 0);
    check("mid_rst_lookup_ready", PC_W'(lookup_ready), 1);
    check("mid_rst_update_ready", PC_W'(update_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    lookup(32'h48, 1'b0, 1'b0, 32'h0);
    lookup(32'h5c, 1'b0, 1'b0, 32'h0);
    lookup(32'h80, 1'b0, 1'b0, 32'h0);

`ifdef BTB_CTRL_FLUSH_EN
    // Flush walk: 16 stalled cycles, enqueue still accepted, commit afterwards
    upd_commit(32'h40, 1'b1, 32'h600);
    lookup(32'h40, 1'b1, 1'b1, 32'h600);
    upd_commit(32'h80, 1'b1, 32'h680);
    lookup(32'h80, 1'b1, 1'b1, 32'h680);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("fl_lookup_ready", PC_W'(lookup_ready), 0);
      update_valid = 1'b0;
      if (i == 3) begin
        update_valid  = 1'b1;
        update_pc     = 32'h48;
        update_taken  = 1'b1;
        update_target = 32'h700;
      end
      if (i > 3) check("fl_qcount_hold", PC_W'(queue_count), 1);
      tick();
    end
    update_valid = 1'b0;
    check("fl_ready_after", PC_W'(lookup_ready), 1);
    lookup(32'h40, 1'b0, 1'b0, 32'h0);
    lookup(32'h80, 1'b0, 1'b0, 32'h0);
    tick();
    check("fl_qcount_commit", PC_W'(queue_count), 0);
    lookup(32'h48, 1'b1, 1'b1, 32'h700);
`endif

    repeat (3) tick();
    check("sb_empty", PC_W'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer_ctrl.md
# branch_target_buffer_ctrl

Controller that owns the branch target buffer table and sequences all access to it. It serves fetch-stage prediction lookups and execute-stage resolution updates through one table port. Each resolved update applies the 2-bit saturating-counter transition to the addressed entry. It sits between the fetch PC generator and the execute-stage branch resolution unit.

## Interface
- ENTRIES, 16, number of direct-mapped table entries (power of two); IDX_W = log2(ENTRIES)
- PC_W, 32, program counter width
- UPD_DEPTH, 4, update queue depth (power of two)
- MAX_WAIT, 3, maximum consecutive lookup grants while an update is pending
- btb_ctrl_clk  in  1  clock; all state changes on the rising edge
- btb_ctrl_rst_n  in  1  reset, asynchronous, active-low
- btb_ctrl_lookup_valid  in  1  fetch requests a prediction
- btb_ctrl_lookup_pc  in  PC_W  fetch PC
- btb_ctrl_lookup_ready  out  1  lookup accepted this cycle when high with valid
- btb_ctrl_hit_valid  out  1  registered result strobe
- btb_ctrl_hit  out  1  valid entry with tag match
- btb_ctrl_hit_taken  out  1  predict taken (hit and counter[1])
- btb_ctrl_hit_target  out  PC_W  stored target (0 on miss)
- btb_ctrl_update_valid  in  1  resolved branch
- btb_ctrl_update_pc  in  PC_W  branch PC
- btb_ctrl_update_taken  in  1  actual outcome
- btb_ctrl_update_target  in  PC_W  actual target
- btb_ctrl_update_ready  out  1  queue not full
- btb_ctrl_queue_count  out  log2(UPD_DEPTH)+1  queued updates

## Operation
- Entry: valid, tag = pc[PC_W-1:IDX_W+2], target, 2-bit counter; index = pc[IDX_W+1:2].
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. Taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Updates enter the FIFO when update_valid && update_ready. update_valid with a full queue is dropped.
- Commit (tag hit): apply the counter transition. A taken commit also overwrites target.
- Commit (miss, taken): allocate the entry with valid=1, the new tag and target, counter=10. This evicts the previous occupant.
- Commit (miss, not-taken): no table change.
- Port FSM states: IDLE, LOOKUP, UPDATE, FLUSH (FLUSH only with the macro). The state is re-evaluated every cycle:
  - Queue non-empty and (lookup_valid=0 or wait_cnt==MAX_WAIT): UPDATE. One entry is popped and committed, and wait_cnt is cleared.
  - Else lookup_valid=1: LOOKUP. wait_cnt increments while the queue is non-empty.
  - Else IDLE.
- lookup_ready = 0 exactly when UPDATE is forced by wait_cnt==MAX_WAIT, or in FLUSH. It is otherwise 1.
- A lookup reads table state before any same-cycle commit. Queued but uncommitted updates are not visible to lookups.
- Simultaneous enqueue and pop in one cycle is legal. A full queue that pops in the same cycle still rejects the new update, because update_ready is derived from the registered count.

## Timing
- Lookup latency is 1 cycle. hit_valid pulses for the single cycle after an accepted lookup, and hit/hit_taken/hit_target are valid with it.
- With hit_valid=0, hit, hit_taken and hit_target hold 0.
- An update commits at the earliest 1 cycle after enqueue.
- Worst-case commit delay for the queue head is MAX_WAIT+1 cycles.
- Reset (asynchronous):
  - All entries become invalid with counter 00, queue empty, wait_cnt 0, state IDLE.
  - Outputs go to 0, except lookup_ready=1 and update_ready=1.
  - Reset mid-operation discards queued updates and any pending result.

## Configuration
- BTB_CTRL_FLUSH_EN defined:
  - Adds input btb_ctrl_flush (1 bit). A flush pulse enters FLUSH.
  - FLUSH clears valid on one index per cycle, from 0 to ENTRIES-1, taking ENTRIES cycles.
  - During FLUSH, lookup_ready=0, no commits occur, and enqueue continues.
  - After FLUSH the FSM returns to normal arbitration. A flush asserted during FLUSH restarts at index 0.
- BTB_CTRL_FLUSH_EN undefined: no flush port and no FLUSH state. Entries are invalidated only by reset.

## Test plan
- Reset, then lookup 0x0000_0040 -> next cycle hit_valid=1, hit=0, hit_taken=0, hit_target=0.
- Taken update 0x40 -> 0x100 with lookups idle -> lookup 0x40 returns hit=1, hit_taken=1, target 0x100. After two not-taken updates (10->01->00) the same lookup returns hit=1, hit_taken=0.
- Three taken updates on an allocated entry, then one not-taken (counter 11, then 10) -> lookup still reports hit_taken=1.
- lookup_valid held high plus one update -> exactly MAX_WAIT=3 lookups are granted, then lookup_ready=0 for one cycle while the commit occurs. The next lookup observes the new entry.
- lookup_valid held high, five back-to-back updates -> queue_count reaches 4 and update_ready=0. The fifth update is dropped and never committed.
- (BTB_CTRL_FLUSH_EN) Populate 0x40 and 0x80, pulse flush -> lookup_ready=0 for 16 cycles. Both lookups then miss, and an update enqueued during the flush commits afterward.
